// File: rtl/mem_ctrl.sv
// Sequencer for a single-port bitcell array: SETUP/STROBE/HOLD write and SETUP/SAMPLE read.
// Define MEM_CTRL_WRITE_VERIFY_EN to read each written row back and flag mismatches on err.
module mem_ctrl #(
  parameter int ADDR_W     = 2,
  parameter int DATA_W     = 4,
  parameter int STROBE_CYC = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      wdata,
  output logic                   ack,
  output logic                   busy,
  output logic [DATA_W-1:0]      rdata,
  output logic                   err,
  output logic [2**ADDR_W-1:0]   sel,
  output logic                   rw,
  output logic [DATA_W-1:0]      din,
  input  logic [DATA_W-1:0]      dout
);

  localparam int ROWS = 2**ADDR_W;
  localparam logic [3:0] CNT_LAST = 4'(STROBE_CYC - 1);

`ifdef MEM_CTRL_WRITE_VERIFY_EN
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, SAMPLE, VERIFY, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, SAMPLE, DONE} state_t;
`endif

  state_t              state_q, state_d;
  logic [3:0]          cnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  // Outputs are registered from the next state, so the accepting edge must
  // see the live request fields rather than the not-yet-latched copies.
  logic                cur_we;
  logic [ADDR_W-1:0]   cur_addr;
  logic [DATA_W-1:0]   cur_wdata;
  logic                active;
  logic [ROWS-1:0]     sel_d;
  logic [DATA_W-1:0]   din_d;

  assign cur_we    = (state_q == IDLE) ? we    : we_q;
  assign cur_addr  = (state_q == IDLE) ? addr  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? wdata : wdata_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (req) state_d = SETUP;
      SETUP:  state_d = we_q ? STROBE : SAMPLE;
      STROBE: if (cnt_q == CNT_LAST) state_d = HOLD;
`ifdef MEM_CTRL_WRITE_VERIFY_EN
      HOLD:   state_d = VERIFY;
      VERIFY: state_d = DONE;
`else
      HOLD:   state_d = DONE;
`endif
      SAMPLE: state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    active = (state_d != IDLE) && (state_d != DONE);
    sel_d  = '0;
    din_d  = '0;
    if (active) begin
      sel_d = {{(ROWS-1){1'b0}}, 1'b1} << cur_addr;
      if (cur_we) din_d = cur_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack     <= 1'b0;
      busy    <= 1'b0;
      sel     <= '0;
      rw      <= 1'b0;
      din     <= '0;
      rdata   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      cnt_q <= (state_q == STROBE) ? cnt_q + 4'd1 : 4'd0;
      ack   <= (state_d == DONE);
      busy  <= (state_d != IDLE);
      sel   <= sel_d;
      rw    <= (state_d == STROBE);
      din   <= din_d;
      if (state_q == SAMPLE) rdata <= dout;
    end
  end

`ifdef MEM_CTRL_WRITE_VERIFY_EN
  // err is only ever high alongside ack; reads and clean writes leave it low.
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= (state_q == VERIFY) && (dout != wdata_q);
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboarded bench for mem_ctrl with a behavioural 4x4 bitcell array model.
module tb_mem_ctrl;

`ifdef MEM_CTRL_WRITE_VERIFY_EN
  localparam int VX = 1;
`else
  localparam int VX = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, req, we, ack, busy, err, rw;
  logic [1:0] addr;
  logic [3:0] wdata, rdata, din, dout, sel;
  logic       req3, we3, ack3, busy3, err3, rw3;
  logic [1:0] addr3;
  logic [3:0] wdata3, rdata3, din3, sel3;
  logic [3:0] dout3 = 4'h0;

  mem_ctrl #(.ADDR_W(2), .DATA_W(4), .STROBE_CYC(1)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .busy(busy), .rdata(rdata), .err(err), .sel(sel), .rw(rw),
    .din(din), .dout(dout));

  mem_ctrl #(.ADDR_W(2), .DATA_W(4), .STROBE_CYC(3)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .we(we3), .addr(addr3), .wdata(wdata3),
    .ack(ack3), .busy(busy3), .rdata(rdata3), .err(err3), .sel(sel3), .rw(rw3),
    .din(din3), .dout(dout3));

  // array model: one row written per strobe edge, read data only when idle-strobed
  logic [3:0] mem [4];
  logic       stuck0;
  always @(posedge clk) begin
    if (rw) begin
      case (sel)
        4'b0001: mem[0] <= din;
        4'b0010: mem[1] <= din;
        4'b0100: mem[2] <= din;
        4'b1000: mem[3] <= din;
        default: ;
      endcase
    end
  end
  always_comb begin
    dout = 4'h0;
    case (sel)
      4'b0001: dout = mem[0];
      4'b0010: dout = mem[1];
      4'b0100: dout = mem[2];
      4'b1000: dout = mem[3];
      default: dout = 4'h0;
    endcase
    if (rw) dout = 4'h0;
    if (stuck0) dout[0] = 1'b0;
  end

  typedef struct { logic [3:0] rdata; logic err; int lat; } exp_t;
  exp_t sbq[$];
  int nchk = 0, nerr = 0;

  // Drives one access and reports what was observed; comparisons live in the tests.
  task automatic run_access(input logic w, input logic [1:0] a, input logic [3:0] d,
                            output int lat, output int rwc, output int viol,
                            output logic [3:0] sel_s, output logic [3:0] rd_s, output logic err_s);
    logic [3:0] ps, pd;
    @(negedge clk); req = 1; we = w; addr = a; wdata = d;
    @(posedge clk); #1 req = 0; we = 0; addr = 0; wdata = 0;
    lat = -1; rwc = 0; viol = 0; sel_s = 0; rd_s = 0; err_s = 0; ps = 0; pd = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) sel_s = sel;
      if (rw) rwc++;
      if (rw && sel == 4'b0) viol++;
      if (rw && (sel != ps || din != pd)) viol++;
      ps = sel; pd = din;
      if (ack) begin lat = c; rd_s = rdata; err_s = err; break; end
    end
  endtask

  task automatic check_pop(input string nm, input int lat, input logic [3:0] rd, input logic e);
    exp_t x;
    if (sbq.size() == 0) begin nchk++; nerr++; $display("FAIL %s: scoreboard empty", nm); return; end
    x = sbq.pop_front();
    nchk++; if (lat !== x.lat) begin nerr++; $display("FAIL %s latency: got %0d expected %0d", nm, lat, x.lat); end
    nchk++; if (rd !== x.rdata) begin nerr++; $display("FAIL %s rdata: got %0h expected %0h", nm, rd, x.rdata); end
    nchk++; if (e !== x.err) begin nerr++; $display("FAIL %s err: got %0b expected %0b", nm, e, x.err); end
  endtask

  task automatic test_reset();
    int lat;
    rst = 1; req = 1; we = 1; addr = 2'd3; wdata = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nchk++;
    if ({ack, busy, err, rw, sel, din, rdata} !== 15'b0) begin
      nerr++; $display("FAIL reset_outputs: got %0h expected 0", {ack, busy, err, rw, sel, din, rdata});
    end
    rst = 0; req = 1; we = 1; addr = 2'd0; wdata = 4'hC;
    @(posedge clk); #1 req = 0;
    @(negedge clk);
    nchk++; if (busy !== 1'b1) begin nerr++; $display("FAIL first_accept busy: got %0b expected 1", busy); end
    lat = -1;
    for (int c = 2; c <= 20; c++) begin
      @(negedge clk);
      if (ack) begin lat = c; break; end
    end
    nchk++; if (lat !== 4 + VX) begin nerr++; $display("FAIL first_write latency: got %0d expected %0d", lat, 4 + VX); end
  endtask

  task automatic test_write();
    int lat, rwc, viol; logic [3:0] s, rd; logic e;
    sbq.push_back('{rdata: 4'h0, err: 1'b0, lat: 4 + VX});
    run_access(1'b1, 2'd2, 4'hA, lat, rwc, viol, s, rd, e);
    check_pop("write", lat, rd, e);
    nchk++; if (s !== 4'b0100) begin nerr++; $display("FAIL write sel: got %b expected 0100", s); end
    nchk++; if (rwc !== 1) begin nerr++; $display("FAIL write rw_cycles: got %0d expected 1", rwc); end
    nchk++; if (viol !== 0) begin nerr++; $display("FAIL write strobe_rules: got %0d expected 0", viol); end
  endtask

  task automatic test_read();
    int lat, rwc, viol; logic [3:0] s, rd; logic e;
    sbq.push_back('{rdata: 4'hA, err: 1'b0, lat: 3});
    run_access(1'b0, 2'd2, 4'h0, lat, rwc, viol, s, rd, e);
    check_pop("read", lat, rd, e);
    nchk++; if (rwc !== 0) begin nerr++; $display("FAIL read rw_cycles: got %0d expected 0", rwc); end
    nchk++; if (s !== 4'b0100) begin nerr++; $display("FAIL read sel: got %b expected 0100", s); end
  endtask

  task automatic test_back_to_back();
    int lat, rwc, viol, acks, idles, cyc; logic [3:0] s, rd; logic e;
    logic [1:0] ra [3];
    logic [3:0] rv [3];
    ra[0] = 2'd0; ra[1] = 2'd1; ra[2] = 2'd3;
    rv[0] = 4'h3; rv[1] = 4'h6; rv[2] = 4'h9;
    for (int i = 0; i < 3; i++) begin
      sbq.push_back('{rdata: 4'hA, err: 1'b0, lat: 4 + VX});
      run_access(1'b1, ra[i], rv[i], lat, rwc, viol, s, rd, e);
      check_pop("prep_write_rdata_hold", lat, rd, e);
    end
    for (int i = 0; i < 3; i++) sbq.push_back('{rdata: rv[i], err: 1'b0, lat: 0});
    @(negedge clk); req = 1; we = 0; addr = ra[0];
    @(posedge clk);
    acks = 0; idles = 0; cyc = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (!busy) idles++;
      if (ack) begin
        check_pop("b2b_read", 0, rdata, err);
        acks++;
        if (acks == 3) begin cyc = c; req = 0; break; end
        addr = ra[acks];
      end
    end
    repeat (3) @(negedge clk);
    nchk++; if (acks !== 3) begin nerr++; $display("FAIL b2b acks: got %0d expected 3", acks); end
    nchk++; if (idles !== 2) begin nerr++; $display("FAIL b2b idle_gaps: got %0d expected 2", idles); end
    nchk++; if (cyc !== 11) begin nerr++; $display("FAIL b2b span: got %0d expected 11", cyc); end
  endtask

  task automatic test_reset_mid();
    int lat, rwc, viol, acks; logic [3:0] s, rd; logic e; logic seen;
    @(negedge clk); req = 1; we = 1; addr = 2'd1; wdata = 4'h5;
    @(posedge clk); #1 req = 0;
    seen = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (rw) begin seen = 1; break; end
    end
    nchk++; if (!seen) begin nerr++; $display("FAIL midrst strobe_seen: got 0 expected 1"); end
    rst = 1;
    @(negedge clk);
    nchk++;
    if ({ack, busy, err, rw, sel, din, rdata} !== 15'b0) begin
      nerr++; $display("FAIL midrst outputs: got %0h expected 0", {ack, busy, err, rw, sel, din, rdata});
    end
    rst = 0; acks = 0;
    repeat (5) begin @(negedge clk); if (ack || busy) acks++; end
    nchk++; if (acks !== 0) begin nerr++; $display("FAIL midrst no_ack: got %0d expected 0", acks); end
    sbq.push_back('{rdata: 4'h9, err: 1'b0, lat: 3});
    run_access(1'b0, 2'd3, 4'h0, lat, rwc, viol, s, rd, e);
    check_pop("post_reset_read", lat, rd, e);
  endtask

  task automatic test_verify();
    int lat, rwc, viol; logic [3:0] s, rd; logic e;
    stuck0 = 1;
    sbq.push_back('{rdata: 4'h9, err: (VX == 1), lat: 4 + VX});
    run_access(1'b1, 2'd1, 4'h1, lat, rwc, viol, s, rd, e);
    check_pop("verify_stuck", lat, rd, e);
    sbq.push_back('{rdata: 4'h9, err: 1'b0, lat: 4 + VX});
    run_access(1'b1, 2'd1, 4'h2, lat, rwc, viol, s, rd, e);
    check_pop("verify_clean", lat, rd, e);
    stuck0 = 0;
  endtask

  task automatic test_strobe3();
    int first, last, cnt, lat;
    exp_t x;
    sbq.push_back('{rdata: 4'h0, err: 1'b0, lat: 6 + VX});
    @(negedge clk); req3 = 1; we3 = 1; addr3 = 2'd1; wdata3 = 4'hF;
    @(posedge clk); #1 req3 = 0;
    first = -1; last = -1; cnt = 0; lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (rw3) begin cnt++; if (first < 0) first = c; last = c; end
      if (ack3) begin lat = c; break; end
    end
    x = sbq.pop_front();
    nchk++; if (lat !== x.lat) begin nerr++; $display("FAIL strobe3 latency: got %0d expected %0d", lat, x.lat); end
    nchk++; if (cnt !== 3) begin nerr++; $display("FAIL strobe3 rw_cycles: got %0d expected 3", cnt); end
    nchk++; if (last - first !== 2) begin nerr++; $display("FAIL strobe3 contiguous: got span %0d expected 2", last - first); end
  endtask

  initial begin
    rst = 1; req = 0; we = 0; addr = 0; wdata = 0; stuck0 = 0;
    req3 = 0; we3 = 0; addr3 = 0; wdata3 = 0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid();
    test_verify();
    test_strobe3();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL provide parameter ADDR_W, default 2, meaning word-address width (2**ADDR_W words).
REQ-002 SHALL provide parameter DATA_W, default 4, meaning bits per word (bitcells per row).
REQ-003 SHALL provide parameter STROBE_CYC, default 1, meaning cycles rw is held high during a write (legal range 1..15).
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 req  input  1  access request from the host, sampled only in IDLE.
REQ-007 we  input  1  1 = write, 0 = read; latched with req.
REQ-008 addr  input  ADDR_W  word address; latched with req.
REQ-009 wdata  input  DATA_W  write data; latched with req.
REQ-010 ack  output  1  one-cycle completion pulse.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 rdata  output  DATA_W  last read word.
REQ-013 err  output  1  write-verify mismatch flag, valid with ack.
REQ-014 sel  output  2**ADDR_W  one-hot row select to the bitcell array.
REQ-015 rw  output  1  array write strobe (1 = write), common to all rows.
REQ-016 din  output  DATA_W  array input data, common to all rows.
REQ-017 dout  input  DATA_W  array read data; valid only while one row is selected and rw = 0.

Function
REQ-018 SHALL implement FSM states IDLE, SETUP, STROBE, HOLD, SAMPLE, VERIFY, DONE, with all outputs registered.
REQ-019 IDLE: req = 1 SHALL latch we/addr/wdata and go to SETUP; req = 0 SHALL stay in IDLE.
REQ-020 SETUP (1 cycle): sel = one-hot(addr), rw = 0, din = wdata for a write or 0 for a read; next state is STROBE on a write, SAMPLE on a read.
REQ-021 STROBE: rw = 1 with sel and din stable, for exactly STROBE_CYC cycles (counted internally), then HOLD.
REQ-022 HOLD (1 cycle): rw = 0 with sel and din unchanged; next state is VERIFY when the macro is defined, else DONE.
REQ-023 SAMPLE (1 cycle): rw = 0 with sel held; rdata SHALL load dout at the edge leaving SAMPLE; next state is DONE.
REQ-024 DONE (1 cycle): ack = 1, sel = 0, rw = 0; next state is IDLE.
REQ-025 rw SHALL never be 1 while sel is all-zero; sel and din SHALL never change in the same cycle that rw is 1.
REQ-026 Latency from the req-accepting edge to the first ack-high cycle: read 3 cycles; write 3 + STROBE_CYC cycles (+1 with the macro).
REQ-027 req while busy SHALL be ignored, including during DONE; the earliest next acceptance is the IDLE cycle following DONE.
REQ-028 rdata SHALL change only on read completion and holds across writes.
REQ-029 sel SHALL be all-zero in IDLE and DONE; din SHALL return to 0 in DONE.
REQ-030 The full decode of addr leaves no out-of-range addresses.

Reset
REQ-031 rst = 1 at a rising edge SHALL force IDLE and set ack, busy, err, rw, sel, din, rdata and the strobe counter to 0, overriding all other inputs.
REQ-032 Reset mid-operation (any state) SHALL abort the access with no ack; array contents are then unspecified for the aborted row only.
REQ-033 The first req is accepted at the first edge with rst = 0.

Configuration
REQ-034 Macro MEM_CTRL_WRITE_VERIFY_EN defined: on writes HOLD SHALL go to VERIFY (1 cycle, rw = 0, sel held), compare dout with the latched wdata, and set err = 1 with ack on mismatch, else err = 0; reads set err = 0.
REQ-035 Macro undefined: no VERIFY state, err is tied to 0, and write latency is 3 + STROBE_CYC.

Verification
REQ-036 Write addr = 2, wdata = 4'hA (STROBE_CYC = 1, macro off) -> sel = 4'b0100 for SETUP through HOLD, rw high exactly 1 cycle, ack 4 cycles after acceptance, err = 0.
REQ-037 Read addr = 2 after REQ-036 with the array model -> rdata = 4'hA, ack 3 cycles after acceptance, rw stays 0 throughout.
REQ-038 req held high continuously for 3 reads -> exactly 3 acks, one per access, with one IDLE cycle between DONE and the next SETUP.
REQ-039 Assert rst during STROBE of a write -> next cycle all outputs 0, no ack, next req accepted normally.
REQ-040 Macro on, array model forcing dout bit 0 stuck at 0, write 4'h1 -> ack with err = 1 at cycle 5; write 4'h2 -> err = 0.
REQ-041 STROBE_CYC = 3, write -> rw high exactly 3 consecutive cycles, ack 6 cycles after acceptance (macro off).
